// File: rtl/rom_bus_pkg.sv
// Shared types for the ROM bus arbiter: FSM states, requester IDs and default address width.
package rom_bus_pkg;

  localparam int AW_DEFAULT = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE
  } state_e;

  typedef enum logic [1:0] {
    REQ_CPU,
    REQ_GFX,
    REQ_DL
  } req_id_e;

endpackage

// File: rtl/rom_bus_prio.sv
// Combinational requester picker: dl first, then cpu, with gfx promoted over cpu once starved.
module rom_bus_prio
  import rom_bus_pkg::*;
(
  input  logic    dl_req,
  input  logic    cpu_req,
  input  logic    gfx_req,
  input  logic    starved,
  output logic    valid,
  output req_id_e id
);

  always_comb begin
    valid = dl_req | cpu_req | gfx_req;
    id    = REQ_CPU;
    if (dl_req)
      id = REQ_DL;
    else if (gfx_req && (starved || !cpu_req))
      id = REQ_GFX;
  end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares one ROM between CPU reads, video fetch reads and download writes.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting; grants a requester and latches its address
// ST_READ    | address on the ROM, waiting ROM_LAT cycles for rom_do
// ST_CAPTURE | rom_do registered into the granted port, ack follows
// ST_WRITE   | rom_we high for one cycle with latched address/data
module rom_bus_arbiter
  import rom_bus_pkg::*;
#(
  parameter int AW          = AW_DEFAULT,
  parameter int ROM_LAT     = 1,
  parameter int GFX_MAXWAIT = 7
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_data,
  input  logic          gfx_req,
  input  logic [AW-1:0] gfx_addr,
  output logic          gfx_ack,
  output logic [7:0]    gfx_data,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_din,
  output logic          dl_ack,
  output logic [AW-1:0] rom_addr,
  output logic          rom_we,
  output logic [7:0]    rom_din,
  input  logic [7:0]    rom_do,
  output logic          busy
);

  localparam int              CW       = (GFX_MAXWAIT < 1) ? 1 : $clog2(GFX_MAXWAIT + 1);
  localparam logic [1:0]      LAT_LOAD = 2'(ROM_LAT - 1);
  localparam logic [CW-1:0]   WAIT_MAX = CW'(GFX_MAXWAIT);

  state_e        state;
  state_e        state_next;
  req_id_e       pick_id;
  req_id_e       gnt_id;
  logic          pick_valid;
  logic          starved;
  logic          grant;
  logic [1:0]    lat_cnt;
  logic [CW-1:0] wait_cnt;

  assign starved = (wait_cnt == WAIT_MAX);
  assign grant   = (state == ST_IDLE) && pick_valid;
  assign busy    = (state != ST_IDLE);
  assign rom_we  = (state == ST_WRITE);

  rom_bus_prio u_prio (
    .dl_req  (dl_req),
    .cpu_req (cpu_req),
    .gfx_req (gfx_req),
    .starved (starved),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_next = (pick_id == REQ_DL) ? ST_WRITE : ST_READ;
      ST_READ:    if (lat_cnt == 2'd0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      ST_WRITE:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      gnt_id   <= REQ_CPU;
      lat_cnt  <= 2'd0;
      wait_cnt <= '0;
      rom_addr <= '0;
      rom_din  <= '0;
      cpu_data <= '0;
      gfx_data <= '0;
      cpu_ack  <= 1'b0;
      gfx_ack  <= 1'b0;
      dl_ack   <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      gfx_ack <= 1'b0;
      dl_ack  <= 1'b0;
      if (grant) begin
        gnt_id  <= pick_id;
        lat_cnt <= LAT_LOAD;
        case (pick_id)
          REQ_DL: begin
            rom_addr <= dl_addr;
            rom_din  <= dl_din;
          end
          REQ_GFX: begin
            rom_addr <= gfx_addr;
            wait_cnt <= '0;
          end
          default: begin
            rom_addr <= cpu_addr;
            // only CPU wins that actually kept a pending gfx waiting count
            if (gfx_req && !starved) wait_cnt <= wait_cnt + CW'(1);
          end
        endcase
      end
      if (state == ST_READ && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;
      if (state == ST_CAPTURE) begin
        if (gnt_id == REQ_GFX) begin
          gfx_data <= rom_do;
          gfx_ack  <= 1'b1;
        end else begin
          cpu_data <= rom_do;
          cpu_ack  <= 1'b1;
        end
      end
      if (state == ST_WRITE)
        dl_ack <= 1'b1;
    end
  end

endmodule
